// File: rtl/arm_mem_pkg.sv
// Shared types and defaults for the 32-bit to 16-bit SRAM bridge.
// Holds the controller state encoding and the byte-to-halfword address map.
package arm_mem_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_LO,
    S_WR_HI,
    S_RD_LO,
    S_RD_HI,
    S_DONE
  } sram_state_t;

  localparam int unsigned DEF_BASE_ADDR   = 1024;
  localparam int unsigned DEF_WAIT_CYCLES = 2;
  localparam int unsigned DEF_SRAM_AW     = 18;

  // Halfword index {word, hi}; the caller truncates to its own address width.
  // Addresses below the base wrap through the subtraction.
  function automatic logic [31:0] hw_addr(input logic [31:0] byte_addr,
                                          input logic [31:0] base,
                                          input logic        hi);
    logic [31:0] diff;
    diff = byte_addr - base;
    return {1'b0, diff[31:2], hi};
  endfunction

endpackage

// File: rtl/sram_phase_cnt.sv
// Per-phase wait counter: runs 0..WAIT_CYCLES, cleared by the controller on
// phase entry, flags the last cycle and the cycle just before it.
module sram_phase_cnt #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  output logic o_last,
  output logic o_pre_last
);

  localparam int unsigned CW = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) r_cnt <= '0;
    else                r_cnt <= r_cnt + 1'b1;
  end

  assign o_last     = (r_cnt == CW'(WAIT_CYCLES));
  // With no wait cycles every cycle is last, so there is no "before last".
  assign o_pre_last = (WAIT_CYCLES != 0) && (r_cnt == CW'(WAIT_CYCLES - 1));

endmodule

// File: rtl/sram_ctrl.sv
// MEM-stage controller splitting each 32-bit access into two 16-bit SRAM phases.
// Define SRAM_CTRL_READ_BUF_EN to add a one-entry last-read buffer.
//
// state   | meaning
// IDLE    | waiting for rd_en/wr_en; ready low while a request is present
// WR_LO   | driving bits 15:0 to halfword {word,0}
// WR_HI   | driving bits 31:16 to halfword {word,1}
// RD_LO   | reading halfword {word,0} into read_data[15:0]
// RD_HI   | reading halfword {word,1} into read_data[31:16]
// DONE    | access complete, ready high for one cycle
module sram_ctrl
  import arm_mem_pkg::*;
#(
  parameter int unsigned BASE_ADDR   = DEF_BASE_ADDR,
  parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int unsigned SRAM_AW     = DEF_SRAM_AW
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_wr_en,
  input  logic               i_rd_en,
  input  logic [31:0]        i_address,
  input  logic [31:0]        i_write_data,
  output logic [31:0]        o_read_data,
  output logic               o_ready,
  output logic [SRAM_AW-1:0] o_sram_addr,
  output logic [15:0]        o_sram_dq_o,
  input  logic [15:0]        i_sram_dq_i,
  output logic               o_sram_dq_oe,
  output logic               o_sram_we_n
);

  localparam logic ENTRY_WE_N = (WAIT_CYCLES == 0);

  sram_state_t        r_state;
  logic [SRAM_AW-2:0] r_word;
  logic [31:0]        r_wdata;
  logic [31:0]        r_rdata;
  logic [SRAM_AW-1:0] r_sram_addr;
  logic [15:0]        r_dq_o;
  logic               r_dq_oe;
  logic               r_we_n;
  logic [SRAM_AW-2:0] w_word;
  logic               w_last;
  logic               w_pre_last;
  logic               w_clr;

`ifdef SRAM_CTRL_READ_BUF_EN
  logic               r_buf_vld;
  logic [SRAM_AW-2:0] r_buf_tag;
  logic [31:0]        r_buf_data;
  logic               w_buf_hit;
  assign w_buf_hit = r_buf_vld && (r_buf_tag == w_word);
`endif

  assign w_word = (SRAM_AW-1)'(hw_addr(i_address, 32'(BASE_ADDR), 1'b0) >> 1);
  assign w_clr  = (r_state == S_IDLE) || (r_state == S_DONE) || w_last;

  sram_phase_cnt #(.WAIT_CYCLES(WAIT_CYCLES)) u_phase_cnt (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_clr      (w_clr),
    .o_last     (w_last),
    .o_pre_last (w_pre_last)
  );

  // Pad controls are registered so we_n cannot glitch toward the async SRAM.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_word      <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_sram_addr <= '0;
      r_dq_o      <= '0;
      r_dq_oe     <= 1'b0;
      r_we_n      <= 1'b1;
`ifdef SRAM_CTRL_READ_BUF_EN
      r_buf_vld   <= 1'b0;
      r_buf_tag   <= '0;
      r_buf_data  <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_wr_en) begin
            r_state     <= S_WR_LO;
            r_word      <= w_word;
            r_wdata     <= i_write_data;
            r_sram_addr <= {w_word, 1'b0};
            r_dq_o      <= i_write_data[15:0];
            r_dq_oe     <= 1'b1;
            r_we_n      <= ENTRY_WE_N;
`ifdef SRAM_CTRL_READ_BUF_EN
            if (w_buf_hit) r_buf_data <= i_write_data;
`endif
          end else if (i_rd_en) begin
`ifdef SRAM_CTRL_READ_BUF_EN
            if (w_buf_hit) begin
              r_state <= S_DONE;
              r_rdata <= r_buf_data;
            end else begin
              r_state     <= S_RD_LO;
              r_word      <= w_word;
              r_sram_addr <= {w_word, 1'b0};
            end
`else
            r_state     <= S_RD_LO;
            r_word      <= w_word;
            r_sram_addr <= {w_word, 1'b0};
`endif
          end
        end
        S_WR_LO: begin
          if (w_last) begin
            r_state     <= S_WR_HI;
            r_sram_addr <= {r_word, 1'b1};
            r_dq_o      <= r_wdata[31:16];
            r_we_n      <= ENTRY_WE_N;
          end else begin
            r_we_n <= w_pre_last;
          end
        end
        S_WR_HI: begin
          if (w_last) begin
            r_state     <= S_DONE;
            r_sram_addr <= '0;
            r_dq_o      <= '0;
            r_dq_oe     <= 1'b0;
            r_we_n      <= 1'b1;
          end else begin
            r_we_n <= w_pre_last;
          end
        end
        S_RD_LO: begin
          if (w_last) begin
            r_state        <= S_RD_HI;
            r_rdata[15:0]  <= i_sram_dq_i;
            r_sram_addr    <= {r_word, 1'b1};
          end
        end
        S_RD_HI: begin
          if (w_last) begin
            r_state        <= S_DONE;
            r_rdata[31:16] <= i_sram_dq_i;
            r_sram_addr    <= '0;
`ifdef SRAM_CTRL_READ_BUF_EN
            r_buf_vld  <= 1'b1;
            r_buf_tag  <= r_word;
            r_buf_data <= {i_sram_dq_i, r_rdata[15:0]};
`endif
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_ready      = (r_state == S_DONE) ||
                        ((r_state == S_IDLE) && !i_wr_en && !i_rd_en);
  assign o_read_data  = r_rdata;
  assign o_sram_addr  = r_sram_addr;
  assign o_sram_dq_o  = r_dq_o;
  assign o_sram_dq_oe = r_dq_oe;
  assign o_sram_we_n  = r_we_n;

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl with a small behavioural async SRAM model.
// Buffer-hit expectations follow SRAM_CTRL_READ_BUF_EN when it is defined.
module tb_sram_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_o;
  logic [15:0] sram_dq_i;
  logic        sram_dq_oe;
  logic        sram_we_n;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] mem [0:255];
  logic        mem_init = 1'b1;

  always #5 clk = ~clk;

  sram_ctrl dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_wr_en      (wr_en),
    .i_rd_en      (rd_en),
    .i_address    (address),
    .i_write_data (write_data),
    .o_read_data  (read_data),
    .o_ready      (ready),
    .o_sram_addr  (sram_addr),
    .o_sram_dq_o  (sram_dq_o),
    .i_sram_dq_i  (sram_dq_i),
    .o_sram_dq_oe (sram_dq_oe),
    .o_sram_we_n  (sram_we_n)
  );

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'hFFFF;
    end else if (!sram_we_n && sram_dq_oe) begin
      mem[sram_addr[7:0]] <= sram_dq_o;
    end
  end

  assign sram_dq_i = sram_dq_oe ? 16'h0000 : mem[sram_addr[7:0]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One pipeline access: request held until ready, counts frozen cycles,
  // write-strobe-low cycles and cycles spent on odd (HI) halfword addresses.
  task automatic access(input logic wr, input logic rd, input logic [31:0] a,
                        input logic [31:0] d, output int frz, output int welo,
                        output int hi, output logic [31:0] rdata);
    bit done;
    @(negedge clk);
    wr_en = wr; rd_en = rd; address = a; write_data = d;
    #1;
    frz = 0; welo = 0; hi = 0; done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (ready) done = 1;
      else begin
        frz++;
        if (!sram_we_n) welo++;
        if (sram_addr[0]) hi++;
        @(negedge clk);
        #1;
      end
    end
    if (!done) check("timeout", 32'd0, 32'd1);
    rdata = read_data;
    wr_en = 0; rd_en = 0;
  endtask

  int frz, welo, hi;
  logic [31:0] rd;
`ifdef SRAM_CTRL_READ_BUF_EN
  localparam int HIT_FRZ = 1;
  localparam int HIT_HI  = 0;
`else
  localparam int HIT_FRZ = 7;
  localparam int HIT_HI  = 3;
`endif

  initial begin
    repeat (3) @(negedge clk);
    mem_init = 1'b0;
    #1;
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_we_n", {31'd0, sram_we_n}, 32'd1);
    check("rst_oe", {31'd0, sram_dq_oe}, 32'd0);
    check("rst_addr", {14'd0, sram_addr}, 32'd0);
    check("rst_dq_o", {16'd0, sram_dq_o}, 32'd0);
    check("rst_rdata", read_data, 32'd0);
    rst = 1'b0;

    access(1, 0, 32'd1024, 32'd8192, frz, welo, hi, rd);
    check("wr1024_frz", frz, 7);
    check("wr1024_welo", welo, 4);
    @(negedge clk);
    check("wr1024_m0", {16'd0, mem[0]}, 32'h2000);
    check("wr1024_m1", {16'd0, mem[1]}, 32'h0000);
    check("idle_ready", {31'd0, ready}, 32'd1);

    access(0, 1, 32'd1024, 32'd0, frz, welo, hi, rd);
    check("rd1024_frz", frz, 7);
    check("rd1024_data", rd, 32'h0000_2000);
    check("rd1024_welo", welo, 0);

    access(1, 0, 32'd1028, 32'hDEADBEEF, frz, welo, hi, rd);
    @(negedge clk);
    check("wr1028_m2", {16'd0, mem[2]}, 32'hBEEF);
    check("wr1028_m3", {16'd0, mem[3]}, 32'hDEAD);
    access(0, 1, 32'd1028, 32'd0, frz, welo, hi, rd);
    check("rd1028_data", rd, 32'hDEADBEEF);
    check("rd1028_frz", frz, 7);

    access(1, 1, 32'd1032, 32'h12345678, frz, welo, hi, rd);
    check("both_welo", welo, 4);
    check("both_rdata", rd, 32'hDEADBEEF);
    @(negedge clk);
    check("both_m4", {16'd0, mem[4]}, 32'h5678);
    check("both_m5", {16'd0, mem[5]}, 32'h1234);

    access(0, 1, 32'd1024, 32'd0, frz, welo, hi, rd);
    check("rd1024b_frz", frz, 7);
    check("rd1024b_data", rd, 32'h0000_2000);
    access(0, 1, 32'd1024, 32'd0, frz, welo, hi, rd);
    check("rd1024c_frz", frz, HIT_FRZ);
    check("rd1024c_hi", hi, HIT_HI);
    check("rd1024c_data", rd, 32'h0000_2000);

    access(1, 0, 32'd1024, 32'd5, frz, welo, hi, rd);
    access(0, 1, 32'd1024, 32'd0, frz, welo, hi, rd);
    check("rd5_data", rd, 32'd5);
    check("rd5_frz", frz, HIT_FRZ);

    // Word index wraps modulo 2^17: this lands on halfwords 0 and 1.
    access(1, 0, 32'd1024 + 32'h0008_0000, 32'hAAAA5555, frz, welo, hi, rd);
    @(negedge clk);
    check("wrap_m0", {16'd0, mem[0]}, 32'h5555);
    check("wrap_m1", {16'd0, mem[1]}, 32'hAAAA);
    access(0, 1, 32'd1024, 32'd0, frz, welo, hi, rd);
    check("wrap_rd", rd, 32'hAAAA5555);

    @(negedge clk);
    wr_en = 1; address = 32'd1040; write_data = 32'h0BADF00D;
    repeat (4) @(negedge clk);
    #1;
    check("pre_rst_addr", {14'd0, sram_addr}, 32'd9);
    check("pre_rst_we_n", {31'd0, sram_we_n}, 32'd0);
    rst = 1; wr_en = 0;
    @(negedge clk);
    #1;
    check("mid_rst_ready", {31'd0, ready}, 32'd1);
    check("mid_rst_we_n", {31'd0, sram_we_n}, 32'd1);
    check("mid_rst_oe", {31'd0, sram_dq_oe}, 32'd0);
    check("mid_rst_rdata", read_data, 32'd0);
    rst = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
- MEM-stage controller that sequences every 32-bit data-memory access onto an external 16-bit asynchronous SRAM as two halfword phases.
- Holds the processor pipeline frozen with `ready` low until the access completes.
- Sits between the MEM stage (LDR/STR) and the SRAM pins.
- `ready` is inverted by the top level to drive the freeze input of the IF/ID/EXE/MEM pipeline registers.

Parameters:
- BASE_ADDR, 1024, byte address that maps to SRAM halfword 0.
- WAIT_CYCLES, 2, extra cycles each halfword phase is held; a phase lasts WAIT_CYCLES+1 cycles.
- SRAM_AW, 18, SRAM halfword address width.

Ports:
- clk, in, 1, system clock; all state changes on the rising edge.
- rst, in, 1, synchronous active-high reset.
- wr_en, in, 1, store request from MEM stage.
- rd_en, in, 1, load request from MEM stage.
- address, in, 32, byte address, word aligned.
- write_data, in, 32, store data.
- read_data, out, 32, load result; valid while ready=1 in DONE.
- ready, out, 1, 0 = pipeline must freeze.
- sram_addr, out, SRAM_AW, halfword address.
- sram_dq_o, out, 16, write data to the pad.
- sram_dq_i, in, 16, read data from the pad.
- sram_dq_oe, out, 1, pad output enable.
- sram_we_n, out, 1, active-low write strobe.

Behaviour:
- Address mapping:
  - word = (address - BASE_ADDR) >> 2, truncated modulo 2^(SRAM_AW-1); out-of-range addresses wrap silently.
  - LO phase drives sram_addr = {word,1'b0}, HI phase drives {word,1'b1}.
  - LO carries bits 15:0, HI carries bits 31:16.
- FSM states: IDLE, WR_LO, WR_HI, RD_LO, RD_HI, DONE.
- IDLE:
  - wr_en=1 -> WR_LO. wr_en has priority when rd_en=1 in the same cycle; no read is performed.
  - rd_en=1 -> RD_LO.
  - Otherwise stay in IDLE.
- Address and write data are latched on leaving IDLE; input changes mid-access are ignored.
- Each LO/HI phase lasts WAIT_CYCLES+1 cycles, counted by a phase counter cleared on phase entry.
- Transitions: LO -> HI -> DONE -> IDLE unconditionally. A request still high in the cycle after DONE is treated as a new access.
- Write phases:
  - sram_dq_oe=1 and sram_dq_o = the latched halfword.
  - sram_we_n=0 in all cycles of the phase except the last, where it is 1 (data/address hold).
- Read phases:
  - sram_dq_oe=0, sram_we_n=1.
  - sram_dq_i is sampled in the last cycle of the phase into the low/high half of the read register.
- ready:
  - 1 in IDLE with no request, and in DONE.
  - 0 in IDLE while a request is present, and in all LO/HI states.
  - Freeze length is 1 + 2*(WAIT_CYCLES+1) cycles; 7 cycles at default.
- read_data holds its last value after DONE and is updated only by reads.
- Reset values: state IDLE, counter 0, read_data 0, ready 1, sram_we_n 1, sram_dq_oe 0, sram_addr 0, sram_dq_o 0.
- Reset asserted mid-access aborts the access immediately. The SRAM content is undefined for a partially written word.

Optional Feature:
- Macro SRAM_CTRL_READ_BUF_EN adds a one-entry last-read buffer: valid bit, word tag, 32-bit data.
- A read in IDLE whose word matches a valid tag goes straight to DONE with the buffered data. ready is 0 for exactly one cycle and the SRAM is not touched.
- Every completed read refills the buffer.
- A write to the tagged word updates the buffered data.
- Reset clears the valid bit.
- Without the macro, every read takes the full SRAM sequence.

Decomposition:
- Package arm_mem_pkg holds:
  - the state enum type;
  - BASE_ADDR and WAIT_CYCLES defaults;
  - SRAM_AW;
  - a function mapping a byte address to a halfword address.
- One natural sub-module, sram_phase_cnt: a wait counter with a clear input and a last-cycle flag.

Test Plan:
- wr_en, address=1024, write_data=8192 -> sram_addr 0 gets 0x2000 and sram_addr 1 gets 0x0000; sram_we_n pulses low for 2 cycles per phase; ready low 7 cycles, then high 1 cycle.
- rd_en, address=1024, behavioural SRAM model -> read_data=8192 in DONE; ready low exactly 7 cycles.
- wr_en, address=1028, data 0xDEADBEEF, then read 1028 -> sram_addr 2=0xBEEF, sram_addr 3=0xDEAD; read_data=0xDEADBEEF.
- wr_en=rd_en=1, address 1032, data 0x12345678 -> a write is performed and read_data is unchanged.
- rst pulsed during WR_HI -> next cycle state IDLE, ready=1, sram_we_n=1, sram_dq_oe=0, read_data=0.
- With SRAM_CTRL_READ_BUF_EN: read 1024 twice -> second read has ready low 1 cycle and no SRAM address activity. A write of 5 to 1024 followed by a read returns 5.
